instr_seq_ctrl: RTL and testbench
=================================

Name: instr_seq_ctrl

Overview:
- Instruction sequencer for the down-sampling processor.
- Owns the program counter and drives the address of the synchronous instruction ROM (1-cycle registered read, 8-bit words, locations 0..PROG_LAST).
- Decodes flow control (JUMP, JMPZ, JMNZ, NOP) itself and issues every other opcode to the datapath control unit over a valid/ready handshake.
- Sits between the instruction ROM and the datapath control FSM.

Parameters:
- PROG_LAST, 120, highest valid ROM address.
- RESET_PC, 0, PC loaded on reset and on start.
- OP_JUMP, 30, unconditional jump opcode.
- OP_JMPZ, 33, jump-if-zero opcode.
- OP_JMNZ, 38, jump-if-not-zero opcode.
- OP_NOP, 2, end-of-program opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins execution from RESET_PC when in IDLE or HALT.
- iram_addr  out  8  ROM address, driven directly from the PC register.
- iram_dout  in  8  ROM read data, valid one cycle after the address is presented.
- op_valid  out  1  opcode on op_code is pending for the datapath.
- op_ready  in  1  datapath accepts and has completed the op (transfer when op_valid and op_ready).
- op_code  out  8  opcode issued to the datapath.
- z_flag  in  1  datapath zero flag; stable whenever op_valid=0.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky error, cleared by start or rst.
- pc  out  8  current PC, for debug.
- issue_cnt  out  16  number of opcodes transferred; saturates at 0xFFFF.

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE, pc=RESET_PC, op_valid=0, op_code=0, busy=0, halted=0, err=0, issue_cnt=0. Reset overrides everything, including a pending handshake; the op is dropped.
- IDLE: on start, go to FETCH with pc=RESET_PC, err=0, issue_cnt=0.
- FETCH (1 cycle): iram_addr=pc, and the ROM captures it. Next state is DECODE.
- DECODE (1 cycle): iram_dout holds the opcode at pc.
  - opcode==OP_NOP -> HALT; pc is held.
  - opcode==0 (illegal) -> err=1, go to HALT.
  - opcode is a branch -> pc<=pc+1, go to TFETCH.
  - otherwise -> op_code<=opcode, op_valid<=1, go to ISSUE.
- ISSUE: op_valid and op_code are held stable until op_ready.
  - On the transfer cycle: op_valid<=0, issue_cnt++, pc<=pc+1, go to FETCH.
  - Minimum 3 cycles per datapath op (FETCH, DECODE, ISSUE).
- TFETCH (1 cycle): the ROM captures pc, which is the target operand address. Next state is TDECODE.
- TDECODE: target = iram_dout; z_flag is sampled this cycle.
  - taken = JUMP, or (JMPZ and z=1), or (JMNZ and z=0).
  - taken -> pc<=target.
  - not taken -> pc<=pc+1, skipping the operand.
  - Then go to FETCH.
  - A branch costs 4 cycles and issues nothing to the datapath.
- HALT: halted=1, busy=0. start re-enters FETCH at RESET_PC with err cleared and issue_cnt cleared.
- Bounds:
  - Any pc update whose result exceeds PROG_LAST (increment, including increment past 255, or a taken target) sets err=1 and goes to HALT; pc keeps its old value.
  - A branch opcode at PROG_LAST has no operand slot: err=1, HALT.
- start is ignored while busy. If start and rst coincide, rst wins.
- op_code keeps its last value after transfer; the consumer qualifies it with op_valid.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds inputs step_mode (1) and step (1-cycle pulse).
  - With step_mode=1, the FSM waits before each FETCH in a STALL state until step is seen; busy stays high.
  - With step_mode=0, behaviour is identical to the base design.
- Undefined: no extra ports and no STALL state.

Decomposition:
- Shared package proc_isa_pkg: all opcode constants (FETCH..JMNZ, MVAC*, ALU ops) and the sequencer state enum. Both the ROM contents and the datapath control import it.
- One natural sub-module, seq_branch_eval: combinational taken/target-range check from opcode, z_flag, target and PROG_LAST.
- PC, state register and counter stay in the top module.

Test Plan:
- ROM {0:CLAC(7), 1:INAC(8), 2:NOP}, op_ready tied high, start -> op_code 7 then 8, each op_valid for exactly 1 cycle 3 cycles apart; halted=1, issue_cnt=2, pc=2.
- Same program with op_ready delayed 5 cycles on op 1 -> op_valid and op_code=8 held stable 5 cycles; no extra issue.
- ROM {0:JMPZ, 1:5, 2:INAC, 3:NOP, 5:DEAC(9), 6:NOP}:
  - z=1 -> only 9 is issued, halt at pc=6.
  - z=0 -> only 8 is issued, halt at pc=3.
- ROM {0:JUMP, 1:121} -> no ops issued, err=1, halted=1, pc=1.
- rst asserted while in ISSUE with op_valid=1 -> next cycle op_valid=0, pc=0, state IDLE, issue_cnt=0; a later start re-executes from 0.
- Illegal opcode 0 at address 0 -> err=1, HALT after 2 cycles; start with a valid program clears err.

Source files
------------

// File: rtl/proc_isa_pkg.sv
// proc_isa_pkg
// Shared ISA definitions for the down-sampling processor: the opcode map used
// by the instruction ROM image, the sequencer and the datapath control FSM,
// plus the sequencer state enum.
// Optional build macro: SEQ_SINGLE_STEP_EN adds the STALL state used by
// single-step execution.
package proc_isa_pkg;

    // Opcode map. Zero is reserved as the illegal opcode so that an erased
    // or unprogrammed ROM word stops the machine instead of running on.
    localparam logic [7:0] OPC_ILLEGAL = 8'd0;
    localparam logic [7:0] OPC_FETCH   = 8'd1;
    localparam logic [7:0] OPC_NOP     = 8'd2;   // end of program
    localparam logic [7:0] OPC_LDAC    = 8'd3;
    localparam logic [7:0] OPC_STAC    = 8'd4;
    localparam logic [7:0] OPC_MVACR   = 8'd5;
    localparam logic [7:0] OPC_MVACRI  = 8'd6;
    localparam logic [7:0] OPC_CLAC    = 8'd7;
    localparam logic [7:0] OPC_INAC    = 8'd8;
    localparam logic [7:0] OPC_DEAC    = 8'd9;
    localparam logic [7:0] OPC_ADD     = 8'd10;
    localparam logic [7:0] OPC_SUB     = 8'd11;
    localparam logic [7:0] OPC_MUL     = 8'd12;
    localparam logic [7:0] OPC_DIV     = 8'd13;
    localparam logic [7:0] OPC_SHL     = 8'd14;
    localparam logic [7:0] OPC_SHR     = 8'd15;
    localparam logic [7:0] OPC_JUMP    = 8'd30;  // JUMP <target>
    localparam logic [7:0] OPC_JMPZ    = 8'd33;  // JMPZ <target>
    localparam logic [7:0] OPC_JMNZ    = 8'd38;  // JMNZ <target>

    // Highest ROM address holding program code.
    localparam int unsigned SEQ_PROG_LAST = 120;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_ISSUE   = 3'd3,
        S_TFETCH  = 3'd4,
        S_TDECODE = 3'd5,
        S_HALT    = 3'd6
`ifdef SEQ_SINGLE_STEP_EN
        ,
        S_STALL   = 3'd7
`endif
    } seq_state_t;

endpackage

// File: rtl/seq_branch_eval.sv
// seq_branch_eval
// Combinational branch resolution. Given the branch opcode latched at DECODE,
// the datapath zero flag, the target read from the operand slot and the
// operand address, produce the next PC and flag a destination outside the
// program area.
// Ports:
//   opcode     in  8  branch opcode (JUMP/JMPZ/JMNZ)
//   z_flag     in  1  datapath zero flag
//   target     in  8  target address read from the operand slot
//   operand_pc in  8  address of the operand slot
//   next_pc    out 8  resolved PC (target if taken, operand_pc+1 if not)
//   range_err  out 1  resolved PC exceeds PROG_LAST
module seq_branch_eval #(
    parameter int unsigned PROG_LAST = 120,
    parameter logic [7:0]  OP_JUMP   = 8'd30,
    parameter logic [7:0]  OP_JMPZ   = 8'd33,
    parameter logic [7:0]  OP_JMNZ   = 8'd38
) (
    input  logic [7:0] opcode,
    input  logic       z_flag,
    input  logic [7:0] target,
    input  logic [7:0] operand_pc,
    output logic [7:0] next_pc,
    output logic       range_err
);
    localparam logic [8:0] LAST9 = 9'(PROG_LAST);

    logic       taken;
    logic [8:0] skip_pc;
    logic [8:0] dest;

    assign taken = (opcode == OP_JUMP)
                 | ((opcode == OP_JMPZ) &  z_flag)
                 | ((opcode == OP_JMNZ) & ~z_flag);

    // Not taken resumes after the operand slot; 9 bits so 255+1 is caught.
    assign skip_pc   = {1'b0, operand_pc} + 9'd1;
    assign dest      = taken ? {1'b0, target} : skip_pc;
    assign range_err = dest > LAST9;
    assign next_pc   = dest[7:0];

endmodule

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl
// Instruction sequencer. Owns the PC, fetches from a synchronous ROM
// (1-cycle registered read), resolves JUMP/JMPZ/JMNZ/NOP locally and hands
// every other opcode to the datapath control FSM over valid/ready.
// Optional build macro: SEQ_SINGLE_STEP_EN (adds step_mode/step inputs; with
// step_mode=1 every FETCH is preceded by a STALL that waits for step).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   step_mode, step  single-step controls (SEQ_SINGLE_STEP_EN only)
//   start            pulse; starts at RESET_PC from IDLE or HALT
//   iram_addr        ROM address (= pc)
//   iram_dout        ROM data, one cycle after the address
//   op_valid/op_ready/op_code  datapath issue handshake
//   z_flag           datapath zero flag
//   busy, halted, err          status (err is sticky until start/rst)
//   pc               current PC
//   issue_cnt        transferred-op count, saturating
module instr_seq_ctrl
    import proc_isa_pkg::*;
#(
    parameter int unsigned PROG_LAST = SEQ_PROG_LAST,
    parameter logic [7:0]  RESET_PC  = 8'd0,
    parameter logic [7:0]  OP_JUMP   = OPC_JUMP,
    parameter logic [7:0]  OP_JMPZ   = OPC_JMPZ,
    parameter logic [7:0]  OP_JMNZ   = OPC_JMNZ,
    parameter logic [7:0]  OP_NOP    = OPC_NOP
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step_mode,
    input  logic        step,
`endif
    input  logic        start,
    output logic [7:0]  iram_addr,
    input  logic [7:0]  iram_dout,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  op_code,
    input  logic        z_flag,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [7:0]  pc,
    output logic [15:0] issue_cnt
);
    localparam logic [8:0] LAST9 = 9'(PROG_LAST);

    seq_state_t  state, state_n;
    seq_state_t  fetch_entry;
    logic [7:0]  pc_n, op_code_n, br_op, br_op_n;
    logic        op_valid_n, err_n;
    logic [15:0] issue_cnt_n;
    logic [8:0]  pc_inc;
    logic        inc_oob;
    logic        is_branch;
    logic [7:0]  br_next_pc;
    logic        br_range_err;

    assign iram_addr = pc;
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);

    // 9-bit increment so that wrapping past 255 is an overflow, not a jump.
    assign pc_inc  = {1'b0, pc} + 9'd1;
    assign inc_oob = pc_inc > LAST9;

    assign is_branch = (iram_dout == OP_JUMP) || (iram_dout == OP_JMPZ)
                    || (iram_dout == OP_JMNZ);

`ifdef SEQ_SINGLE_STEP_EN
    assign fetch_entry = step_mode ? S_STALL : S_FETCH;
`else
    assign fetch_entry = S_FETCH;
`endif

    // In TDECODE iram_dout carries the target, so the branch opcode comes
    // from br_op, latched at DECODE.
    seq_branch_eval #(
        .PROG_LAST (PROG_LAST),
        .OP_JUMP   (OP_JUMP),
        .OP_JMPZ   (OP_JMPZ),
        .OP_JMNZ   (OP_JMNZ)
    ) u_branch (
        .opcode     (br_op),
        .z_flag     (z_flag),
        .target     (iram_dout),
        .operand_pc (pc),
        .next_pc    (br_next_pc),
        .range_err  (br_range_err)
    );

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        op_valid_n  = op_valid;
        op_code_n   = op_code;
        err_n       = err;
        issue_cnt_n = issue_cnt;
        br_op_n     = br_op;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_n     = fetch_entry;
                    pc_n        = RESET_PC;
                    err_n       = 1'b0;
                    issue_cnt_n = '0;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (iram_dout == OP_NOP) begin
                    state_n = S_HALT;
                end else if (iram_dout == 8'd0) begin
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else if (is_branch) begin
                    br_op_n = iram_dout;
                    // A branch at PROG_LAST has no operand slot.
                    if (inc_oob) begin
                        err_n   = 1'b1;
                        state_n = S_HALT;
                    end else begin
                        pc_n    = pc_inc[7:0];
                        state_n = S_TFETCH;
                    end
                end else begin
                    op_code_n  = iram_dout;
                    op_valid_n = 1'b1;
                    state_n    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    op_valid_n = 1'b0;
                    if (issue_cnt != 16'hFFFF)
                        issue_cnt_n = issue_cnt + 16'd1;
                    if (inc_oob) begin
                        err_n   = 1'b1;
                        state_n = S_HALT;
                    end else begin
                        pc_n    = pc_inc[7:0];
                        state_n = fetch_entry;
                    end
                end
            end
            S_TFETCH: state_n = S_TDECODE;
            S_TDECODE: begin
                if (br_range_err) begin
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else begin
                    pc_n    = br_next_pc;
                    state_n = fetch_entry;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_STALL: if (step) state_n = S_FETCH;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            op_valid  <= 1'b0;
            op_code   <= 8'd0;
            err       <= 1'b0;
            issue_cnt <= 16'd0;
            br_op     <= 8'd0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            op_valid  <= op_valid_n;
            op_code   <= op_code_n;
            err       <= err_n;
            issue_cnt <= issue_cnt_n;
            br_op     <= br_op_n;
        end
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl
// Bench for instr_seq_ctrl: a behavioural ROM, a datapath stub with
// programmable/random ready latency, and an ISA-level interpreter that
// predicts the issued ops, final pc, err and cycle count of each program.
module tb_instr_seq_ctrl;
    import proc_isa_pkg::*;

    localparam int LAST = 120;

    logic        clk = 1'b0;
    logic        rst, start, op_ready, z_flag;
    logic [7:0]  iram_addr, iram_dout, op_code, pc;
    logic        op_valid, busy, halted, err;
    logic [15:0] issue_cnt;

    logic [7:0]  rom [256];
    logic [7:0]  obs_q[$], exp_q[$];
    int          dly_q[$], xfer_cyc[$];
    int          checks = 0, failures = 0;
    int          exp_pc, exp_err, exp_cyc;
    int          run_cyc, dly_sum, valid_cyc, proto_errs, max_dly;
    bit          start_noise;

    always #5 clk = ~clk;
    always @(posedge clk) iram_dout <= rom[iram_addr];

    instr_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .iram_addr (iram_addr),
        .iram_dout (iram_dout),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .z_flag    (z_flag),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .pc        (pc),
        .issue_cnt (issue_cnt)
    );

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = OPC_NOP;
    endtask

    // Interpret the program in rom[] as the ISA defines it.
    task automatic model(input logic z);
        int p, np;
        logic [7:0] op;
        bit tk;
        exp_q.delete();
        p = 0; exp_err = 0; exp_cyc = 1;
        for (int n = 0; n < 400; n++) begin
            op = rom[p];
            if (op == OPC_NOP) begin exp_cyc += 2; break; end
            if (op == 8'd0) begin exp_cyc += 2; exp_err = 1; break; end
            if (op == OPC_JUMP || op == OPC_JMPZ || op == OPC_JMNZ) begin
                if (p == LAST) begin exp_cyc += 2; exp_err = 1; break; end
                exp_cyc += 4;
                tk = (op == OPC_JUMP) || (op == OPC_JMPZ && z) || (op == OPC_JMNZ && !z);
                np = tk ? int'(rom[p+1]) : p + 2;
                if (np > LAST) begin exp_err = 1; p = p + 1; break; end
                p = np;
            end else begin
                exp_q.push_back(op);
                exp_cyc += 3;
                if (p + 1 > LAST) begin exp_err = 1; break; end
                p++;
            end
        end
        exp_pc = p;
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Pulse start, then act as the datapath until halted. Cycle k is the k-th
    // falling edge after the start edge.
    task automatic run_prog();
        int hold, cyc;
        logic [7:0] held;
        obs_q.delete(); xfer_cyc.delete();
        dly_sum = 0; valid_cyc = 0; proto_errs = 0; hold = -1; cyc = 0; held = 8'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        forever begin
            cyc++;
            if (halted) break;
            if (cyc > 3000) begin
                proto_errs++;
                $display("FAIL run_timeout halted=%0b want 1 within 3000 cycles", halted);
                break;
            end
            start = start_noise && ($urandom_range(0, 7) == 0);
            if (op_valid) begin
                valid_cyc++;
                if (hold < 0) begin
                    hold = (dly_q.size() > 0) ? dly_q.pop_front() : int'($urandom_range(0, max_dly));
                    dly_sum += hold;
                    held = op_code;
                end else if (op_code !== held) begin
                    proto_errs++;
                    $display("FAIL op_code_hold got %0d want %0d", op_code, held);
                end
                if (hold == 0) begin
                    op_ready = 1'b1;
                    obs_q.push_back(op_code);
                    xfer_cyc.push_back(cyc);
                    hold = -1;
                end else begin
                    op_ready = 1'b0;
                    hold--;
                end
            end else begin
                if (hold >= 0) begin
                    proto_errs++;
                    $display("FAIL op_valid_hold got 0 want 1 at cycle %0d", cyc);
                    hold = -1;
                end
                op_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0; op_ready = 1'b0;
        run_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({op_valid, busy, halted, err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got %b want 0000", {op_valid, busy, halted, err});
        end
        checks++;
        if (pc !== 8'd0 || iram_addr !== 8'd0) begin
            failures++;
            $display("FAIL reset_pc got %0d/%0d want 0/0", pc, iram_addr);
        end
        checks++;
        if (issue_cnt !== 16'd0 || op_code !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt_code got %0d/%0d want 0/0", issue_cnt, op_code);
        end
        rst = 1'b0;
        // start must not have any effect without an edge in IDLE; stay idle.
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy got %b want 0", busy);
        end
    endtask

    task automatic test_programs();
        int fd;
        for (int sc = 0; sc < 10; sc++) begin
            clear_rom(); dly_q.delete();
            max_dly = 0; start_noise = 0; z_flag = 1'b0;
            case (sc)
                0, 6: begin rom[0] = OPC_CLAC; rom[1] = OPC_INAC; end
                1: begin rom[0] = OPC_CLAC; rom[1] = OPC_INAC; dly_q = '{0, 5}; end
                2, 3: begin
                    rom[0] = OPC_JMPZ; rom[1] = 8'd5; rom[2] = OPC_INAC;
                    rom[5] = OPC_DEAC; z_flag = (sc == 2);
                end
                4: begin rom[0] = OPC_JUMP; rom[1] = 8'd121; end
                5: rom[0] = 8'd0;
                7: begin rom[0] = OPC_JUMP; rom[1] = 8'd120; rom[120] = OPC_JMPZ; end
                8: for (int i = 0; i <= LAST; i++) rom[i] = OPC_INAC;
                default: begin
                    rom[0] = OPC_JMNZ; rom[1] = 8'd4; rom[2] = OPC_CLAC; rom[4] = OPC_DEAC;
                end
            endcase
            model(z_flag);
            run_prog();
            fd = first_diff();
            checks++;
            if (fd !== -1) begin
                failures++;
                $display("FAIL prog%0d_ops got n=%0d want n=%0d first_diff=%0d",
                         sc, obs_q.size(), exp_q.size(), fd);
            end
            checks++;
            if (pc !== 8'(exp_pc)) begin
                failures++; $display("FAIL prog%0d_pc got %0d want %0d", sc, pc, exp_pc);
            end
            checks++;
            if (err !== 1'(exp_err)) begin
                failures++; $display("FAIL prog%0d_err got %0b want %0d", sc, err, exp_err);
            end
            checks++;
            if ({halted, busy} !== 2'b10) begin
                failures++; $display("FAIL prog%0d_status halted,busy got %b want 10", sc, {halted, busy});
            end
            checks++;
            if (issue_cnt !== 16'(exp_q.size())) begin
                failures++; $display("FAIL prog%0d_cnt got %0d want %0d", sc, issue_cnt, exp_q.size());
            end
            checks++;
            if (run_cyc !== exp_cyc + dly_sum) begin
                failures++; $display("FAIL prog%0d_cycles got %0d want %0d", sc, run_cyc, exp_cyc + dly_sum);
            end
            checks++;
            if (valid_cyc !== exp_q.size() + dly_sum || proto_errs !== 0) begin
                failures++;
                $display("FAIL prog%0d_valid_cycles got %0d want %0d (protocol errs %0d)",
                         sc, valid_cyc, exp_q.size() + dly_sum, proto_errs);
            end
            if (sc == 0) begin
                checks++;
                if (xfer_cyc.size() != 2 || xfer_cyc[1] - xfer_cyc[0] != 3) begin
                    failures++;
                    $display("FAIL prog0_spacing got n=%0d gap=%0d want n=2 gap=3", xfer_cyc.size(),
                             (xfer_cyc.size() == 2) ? xfer_cyc[1] - xfer_cyc[0] : -1);
                end
            end
        end
    endtask

    task automatic test_reset_in_issue();
        int k;
        clear_rom(); rom[0] = OPC_CLAC; rom[1] = OPC_INAC;
        z_flag = 1'b0; start_noise = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        op_ready = 1'b1; k = 0;
        while (!op_valid && k < 20) begin @(negedge clk); k++; end
        @(negedge clk); op_ready = 1'b0; k = 0;
        while (!op_valid && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b1 || op_code !== OPC_INAC || issue_cnt !== 16'd1) begin
            failures++;
            $display("FAIL rst_issue_pre valid/code/cnt got %b/%0d/%0d want 1/8/1", op_valid, op_code, issue_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({op_valid, busy, halted} !== 3'b000 || pc !== 8'd0 || issue_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rst_issue_post valid,busy,halted=%b pc=%0d cnt=%0d want 000/0/0",
                     {op_valid, busy, halted}, pc, issue_cnt);
        end
        model(1'b0);
        max_dly = 2;
        run_prog();
        checks++;
        if (first_diff() !== -1 || issue_cnt !== 16'd2 || pc !== 8'd2 || err !== 1'b0) begin
            failures++;
            $display("FAIL rst_issue_rerun ops=%0d cnt=%0d pc=%0d err=%b want 2/2/2/0",
                     obs_q.size(), issue_cnt, pc, err);
        end
    endtask

    task automatic test_random();
        int a, len;
        logic z;
        for (int t = 0; t < 25; t++) begin
            clear_rom(); dly_q.delete();
            a = 0; len = $urandom_range(4, LAST + 1);
            while (a < len) begin
                case ($urandom_range(0, 99)) inside
                    [0:11]: begin
                        case ($urandom_range(0, 2))
                            0: rom[a] = OPC_JUMP;
                            1: rom[a] = OPC_JMPZ;
                            default: rom[a] = OPC_JMNZ;
                        endcase
                        rom[a+1] = 8'(a + 2 + $urandom_range(0, 12));
                        a += 2;
                    end
                    [12:13]: begin rom[a] = 8'd0; a++; end
                    default: begin rom[a] = 8'($urandom_range(3, 29)); a++; end
                endcase
            end
            z = 1'($urandom_range(0, 1));
            z_flag = z; max_dly = 3; start_noise = 1;
            model(z);
            run_prog();
            checks++;
            if (first_diff() !== -1) begin
                failures++;
                $display("FAIL rand%0d_ops got n=%0d want n=%0d first_diff=%0d",
                         t, obs_q.size(), exp_q.size(), first_diff());
            end
            checks++;
            if (pc !== 8'(exp_pc) || err !== 1'(exp_err)) begin
                failures++;
                $display("FAIL rand%0d_pc_err got %0d/%b want %0d/%0d", t, pc, err, exp_pc, exp_err);
            end
            checks++;
            if (issue_cnt !== 16'(exp_q.size()) || halted !== 1'b1) begin
                failures++;
                $display("FAIL rand%0d_cnt_halt got %0d/%b want %0d/1", t, issue_cnt, halted, exp_q.size());
            end
            checks++;
            if (run_cyc !== exp_cyc + dly_sum || proto_errs !== 0) begin
                failures++;
                $display("FAIL rand%0d_cycles got %0d want %0d (protocol errs %0d)",
                         t, run_cyc, exp_cyc + dly_sum, proto_errs);
            end
        end
        start_noise = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_ready = 1'b0; z_flag = 1'b0;
        max_dly = 0; start_noise = 0;
        clear_rom();
        test_reset();
        test_programs();
        test_reset_in_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
